// File: rtl/sr_latch_driver.sv
// Command-side driver for a NOR SR latch: turns set/clear requests into timed,
// non-overlapping s/r pulses and verifies the latch feedback after settling.
module sr_latch_driver #(
  parameter int unsigned GAP_W    = 1,
  parameter int unsigned PULSE_W  = 2,
  parameter int unsigned SETTLE_W = 2,
  parameter int unsigned CNT_W    = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic cmd_valid,
  output logic cmd_ready,
  input  logic cmd_set,
  output logic s,
  output logic r,
  input  logic q_fb,
  input  logic qb_fb,
  output logic done,
  output logic fail,
  output logic level,
  output logic fault
);

  // A zero-length phase is treated as one cycle.
  localparam int unsigned GAP_EFF    = (GAP_W == 0) ? 1 : GAP_W;
  localparam int unsigned PULSE_EFF  = (PULSE_W == 0) ? 1 : PULSE_W;
  localparam int unsigned SETTLE_EFF = (SETTLE_W == 0) ? 1 : SETTLE_W;

  localparam logic [CNT_W-1:0] GAP_LOAD    = CNT_W'(GAP_EFF - 1);
  localparam logic [CNT_W-1:0] PULSE_LOAD  = CNT_W'(PULSE_EFF - 1);
  localparam logic [CNT_W-1:0] SETTLE_LOAD = CNT_W'(SETTLE_EFF - 1);

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_GUARD  = 3'd1,
    ST_PULSE  = 3'd2,
    ST_SETTLE = 3'd3,
    ST_CHECK  = 3'd4
  } state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             dir_q, dir_d;
  logic [1:0]       q_sync_q, qb_sync_q;
  logic             s_q, s_d;
  logic             r_q, r_d;
  logic             ready_q, ready_d;
  logic             done_q, done_d;
  logic             fail_q, fail_d;
  logic             level_q, level_d;
  logic             fault_q, fault_d;
  logic             pulse_d;
  logic             fb_ok;

  // Two-flop synchronisers for the asynchronous latch feedback.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q_sync_q  <= 2'b00;
      qb_sync_q <= 2'b00;
    end else begin
      q_sync_q  <= {q_sync_q[0], q_fb};
      qb_sync_q <= {qb_sync_q[0], qb_fb};
    end
  end

  // State, phase counter and all registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      dir_q   <= 1'b0;
      s_q     <= 1'b0;
      r_q     <= 1'b0;
      ready_q <= 1'b1;
      done_q  <= 1'b0;
      fail_q  <= 1'b0;
      level_q <= 1'b0;
      fault_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      dir_q   <= dir_d;
      s_q     <= s_d;
      r_q     <= r_d;
      ready_q <= ready_d;
      done_q  <= done_d;
      fail_q  <= fail_d;
      level_q <= level_d;
      fault_q <= fault_d;
    end
  end

  // Next-state: each timed phase counts down from its load value to zero.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    dir_d   = dir_q;
    case (state_q)
      ST_IDLE: begin
        if (cmd_valid && ready_q) begin
          dir_d   = cmd_set;
          cnt_d   = GAP_LOAD;
          state_d = ST_GUARD;
        end
      end
      ST_GUARD: begin
        if (cnt_q == '0) begin
          cnt_d   = PULSE_LOAD;
          state_d = ST_PULSE;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      ST_PULSE: begin
        if (cnt_q == '0) begin
          cnt_d   = SETTLE_LOAD;
          state_d = ST_SETTLE;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      ST_SETTLE: begin
        if (cnt_q == '0) begin
          cnt_d   = '0;
          state_d = ST_CHECK;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      ST_CHECK: begin
        state_d = ST_IDLE;
      end
      default: begin
        cnt_d   = '0;
        state_d = ST_IDLE;
      end
    endcase
  end

  // Outputs are decoded from the next state so they align with the state register.
  always_comb begin
    pulse_d = 1'b0;
    s_d     = 1'b0;
    r_d     = 1'b0;
    ready_d = 1'b0;
    done_d  = 1'b0;
    fail_d  = 1'b0;
    fb_ok   = 1'b0;
    level_d = level_q;
    fault_d = fault_q;

    pulse_d = (state_d == ST_PULSE);
    s_d     = pulse_d && dir_d;
    r_d     = pulse_d && !dir_d;
    ready_d = (state_d == ST_IDLE);
    done_d  = (state_d == ST_CHECK);

    // q == qb can never satisfy both terms, so it always reports a failure.
    fb_ok   = (q_sync_q[1] == dir_q) && (qb_sync_q[1] == !dir_q);
    fail_d  = done_d && !fb_ok;
    if (done_d && fb_ok) begin
      level_d = dir_q;
    end
    fault_d = fault_q || fail_d;
  end

  assign s         = s_q;
  assign r         = r_q;
  assign cmd_ready = ready_q;
  assign done      = done_q;
  assign fail      = fail_q;
  assign level     = level_q;
  assign fault     = fault_q;

`ifndef SYNTHESIS
  a_no_forbidden_drive: assert property (@(posedge clk) disable iff (!rst_n) !(s_q && r_q));
  a_done_with_ready_low: assert property (@(posedge clk) disable iff (!rst_n) done_q |-> !ready_q);
`endif

endmodule

// File: tb/tb_sr_latch_driver.sv
// Directed bench for sr_latch_driver: default-parameter instance against a NOR
// latch model, plus a widened-timing instance driven by a random command stream.
module tb_sr_latch_driver;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  logic cmd_valid = 1'b0, cmd_set = 1'b0;
  logic cmd_ready, s, r, q_fb, qb_fb, done, fail, level, fault;
  logic lq = 1'b0;
  logic stuck = 1'b0;

  logic cmd_valid2 = 1'b0, cmd_set2 = 1'b0;
  logic cmd_ready2, s2, r2, q_fb2, qb_fb2, done2, fail2, level2, fault2;
  logic lq2 = 1'b0;

  int unsigned n_vec = 0;
  int unsigned n_err = 0;

  // Per-cycle capture {cmd_ready,s,r,done,fail} for cycles 1..7 after accept.
  logic [4:0] trace [0:7];
  logic [1:0] trace_lf;
  logic       exp_level = 1'b0;
  logic       exp_fault = 1'b0;

  always #5 clk = ~clk;

  sr_latch_driver u_dut (
    .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_set(cmd_set), .s(s), .r(r), .q_fb(q_fb), .qb_fb(qb_fb),
    .done(done), .fail(fail), .level(level), .fault(fault)
  );

  sr_latch_driver #(.GAP_W(3), .PULSE_W(4), .SETTLE_W(3), .CNT_W(4)) u_dut_wide (
    .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid2), .cmd_ready(cmd_ready2),
    .cmd_set(cmd_set2), .s(s2), .r(r2), .q_fb(q_fb2), .qb_fb(qb_fb2),
    .done(done2), .fail(fail2), .level(level2), .fault(fault2)
  );

  // NOR latch behaviour: set/reset on exclusive drive, hold otherwise.
  always @(s or r) begin
    if (s && !r) lq = 1'b1;
    else if (r && !s) lq = 1'b0;
  end
  always @(s2 or r2) begin
    if (s2 && !r2) lq2 = 1'b1;
    else if (r2 && !s2) lq2 = 1'b0;
  end

  assign q_fb   = stuck ? 1'b0 : lq;
  assign qb_fb  = stuck ? 1'b1 : ~lq;
  assign q_fb2  = lq2;
  assign qb_fb2 = ~lq2;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  // Starts at a negedge in IDLE, accepts one command, records cycles 1..7.
  task automatic run_cmd(input logic set, input logic keep_valid);
    cmd_valid = 1'b1;
    cmd_set   = set;
    @(posedge clk);
    for (int k = 1; k <= 7; k++) begin
      @(negedge clk);
      if (k == 1) begin
        if (keep_valid) cmd_set = 1'b0;
        else begin
          cmd_valid = 1'b0;
          cmd_set   = 1'($urandom_range(0, 1));
        end
      end
      trace[k] = {cmd_ready, s, r, done, fail};
    end
    trace_lf = {level, fault};
  endtask

  task automatic test_reset;
    logic [6:0] got;
    rst_n = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      cmd_valid = 1'($urandom_range(0, 1));
      cmd_set   = 1'($urandom_range(0, 1));
      got = {cmd_ready, s, r, done, fail, level, fault};
      n_vec++;
      if (got !== 7'b1000000) begin
        n_err++;
        $display("FAIL reset_hold[%0d]: got %b expected %b", i, got, 7'b1000000);
      end
    end
    @(negedge clk);
    cmd_valid = 1'b0;
    rst_n     = 1'b1;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      got = {cmd_ready, s, r, done, fail, level, fault};
      n_vec++;
      if (got !== 7'b1000000) begin
        n_err++;
        $display("FAIL reset_release[%0d]: got %b expected %b", i, got, 7'b1000000);
      end
    end
  endtask

  task automatic test_set;
    logic [4:0] exp;
    run_cmd(1'b1, 1'b1);
    exp_level = 1'b1;
    for (int k = 1; k <= 7; k++) begin
      exp = {k == 7, k == 2 || k == 3, 1'b0, k == 6, 1'b0};
      n_vec++;
      if (trace[k] !== exp) begin
        n_err++;
        $display("FAIL set_cmd cycle %0d: got %b expected %b", k, trace[k], exp);
      end
    end
    n_vec++;
    if (trace_lf !== {exp_level, exp_fault}) begin
      n_err++;
      $display("FAIL set_level_fault: got %b expected %b", trace_lf, {exp_level, exp_fault});
    end
  endtask

  task automatic test_back_to_back;
    logic [4:0] exp;
    run_cmd(1'b0, 1'b0);
    exp_level = 1'b0;
    for (int k = 1; k <= 7; k++) begin
      exp = {k == 7, 1'b0, k == 2 || k == 3, k == 6, 1'b0};
      n_vec++;
      if (trace[k] !== exp) begin
        n_err++;
        $display("FAIL b2b_cmd cycle %0d: got %b expected %b", k, trace[k], exp);
      end
    end
    n_vec++;
    if (trace_lf !== {exp_level, exp_fault}) begin
      n_err++;
      $display("FAIL b2b_level_fault: got %b expected %b", trace_lf, {exp_level, exp_fault});
    end
  endtask

  task automatic test_stuck_feedback;
    logic [4:0] exp;
    @(negedge clk);
    stuck = 1'b1;
    run_cmd(1'b1, 1'b0);
    stuck = 1'b0;
    exp_fault = 1'b1;
    for (int k = 1; k <= 7; k++) begin
      exp = {k == 7, k == 2 || k == 3, 1'b0, k == 6, k == 6};
      n_vec++;
      if (trace[k] !== exp) begin
        n_err++;
        $display("FAIL stuck_cmd cycle %0d: got %b expected %b", k, trace[k], exp);
      end
    end
    n_vec++;
    if (trace_lf !== {exp_level, exp_fault}) begin
      n_err++;
      $display("FAIL stuck_level_fault: got %b expected %b", trace_lf, {exp_level, exp_fault});
    end
    run_cmd(1'b0, 1'b0);
    for (int k = 1; k <= 7; k++) begin
      exp = {k == 7, 1'b0, k == 2 || k == 3, k == 6, 1'b0};
      n_vec++;
      if (trace[k] !== exp) begin
        n_err++;
        $display("FAIL recover_cmd cycle %0d: got %b expected %b", k, trace[k], exp);
      end
    end
    n_vec++;
    if (trace_lf !== {exp_level, exp_fault}) begin
      n_err++;
      $display("FAIL recover_level_fault: got %b expected %b", trace_lf, {exp_level, exp_fault});
    end
  endtask

  task automatic test_async_reset;
    logic [6:0] got;
    logic [4:0] exp;
    cmd_valid = 1'b1;
    cmd_set   = 1'b1;
    @(posedge clk);
    @(negedge clk);
    cmd_valid = 1'b0;
    @(negedge clk);
    n_vec++;
    if (s !== 1'b1) begin
      n_err++;
      $display("FAIL arst_pulse_active: got s=%b expected s=1", s);
    end
    #2 rst_n = 1'b0;
    #1;
    got = {cmd_ready, s, r, done, fail, level, fault};
    n_vec++;
    if (got !== 7'b1000000) begin
      n_err++;
      $display("FAIL arst_immediate: got %b expected %b", got, 7'b1000000);
    end
    exp_level = 1'b0;
    exp_fault = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    got = {cmd_ready, s, r, done, fail, level, fault};
    n_vec++;
    if (got !== 7'b1000000) begin
      n_err++;
      $display("FAIL arst_release: got %b expected %b", got, 7'b1000000);
    end
    run_cmd(1'b1, 1'b0);
    exp_level = 1'b1;
    for (int k = 1; k <= 7; k++) begin
      exp = {k == 7, k == 2 || k == 3, 1'b0, k == 6, 1'b0};
      n_vec++;
      if (trace[k] !== exp) begin
        n_err++;
        $display("FAIL arst_post_cmd cycle %0d: got %b expected %b", k, trace[k], exp);
      end
    end
    n_vec++;
    if (trace_lf !== {exp_level, exp_fault}) begin
      n_err++;
      $display("FAIL arst_post_level_fault: got %b expected %b", trace_lf, {exp_level, exp_fault});
    end
  endtask

  // GAP=3, PULSE=4, SETTLE=3: pulse in cycles 4..7, done in cycle 11.
  task automatic test_param_stream;
    logic       set;
    logic [4:0] got, exp;
    for (int n = 0; n < 200; n++) begin
      set        = 1'($urandom_range(0, 1));
      cmd_valid2 = 1'b1;
      cmd_set2   = set;
      @(posedge clk);
      for (int k = 1; k <= 11; k++) begin
        @(negedge clk);
        cmd_valid2 = 1'($urandom_range(0, 1));
        cmd_set2   = 1'($urandom_range(0, 1));
        got = {cmd_ready2, s2, r2, done2, fail2};
        exp = {1'b0, set && k >= 4 && k <= 7, !set && k >= 4 && k <= 7, k == 11, 1'b0};
        n_vec++;
        if (got !== exp) begin
          n_err++;
          $display("FAIL stream[%0d] cycle %0d: got %b expected %b", n, k, got, exp);
        end
      end
      @(negedge clk);
      got = {cmd_ready2, s2, r2, done2, fail2};
      n_vec++;
      if (got !== 5'b10000 || level2 !== lq2 || level2 !== set) begin
        n_err++;
        $display("FAIL stream_idle[%0d]: got %b level=%b expected 10000 level=%b model_q=%b",
                 n, got, level2, set, lq2);
      end
      if ($urandom_range(0, 2) == 0) begin
        cmd_valid2 = 1'b0;
        @(negedge clk);
        n_vec++;
        if (cmd_ready2 !== 1'b1 || s2 !== 1'b0 || r2 !== 1'b0) begin
          n_err++;
          $display("FAIL stream_gap[%0d]: got ready=%b s=%b r=%b expected 1 0 0",
                   n, cmd_ready2, s2, r2);
        end
      end
    end
    cmd_valid2 = 1'b0;
  endtask

  initial begin
    test_reset();
    test_set();
    test_back_to_back();
    test_stuck_feedback();
    test_async_reset();
    test_param_stream();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/sr_latch_driver.md
Name: sr_latch_driver

Overview:
Command-side driver for the NOR SR latch cell.
- Converts a one-bit set/clear request on a valid/ready handshake into timed, non-overlapping s/r pulses.
- Samples the latch q/qb feedback after settling and reports pass/fail per command.
- Sits between control logic and the latch, and guarantees the forbidden s=r=1 input is never driven.

Parameters:
GAP_W, 1, cycles with s=r=0 before each pulse (>=1)
PULSE_W, 2, cycles s or r held high (>=1)
SETTLE_W, 2, cycles with s=r=0 after pulse before feedback check (>=2, covers synchroniser)
CNT_W, 4, phase counter width; must hold max(GAP_W,PULSE_W,SETTLE_W)

Ports:
clk  in  1  single clock, rising edge
rst_n  in  1  asynchronous active-low reset
cmd_valid  in  1  command request
cmd_ready  out  1  driver idle, command accepted when cmd_valid&cmd_ready at rising edge
cmd_set  in  1  1 = set latch (q=1), 0 = reset latch (q=0); captured at accept
s  out  1  latch set drive, registered
r  out  1  latch reset drive, registered
q_fb  in  1  latch q, asynchronous to clk
qb_fb  in  1  latch qb, asynchronous to clk
done  out  1  one-cycle pulse at end of every command
fail  out  1  valid with done; 1 = feedback mismatch
level  out  1  last successfully verified latch level
fault  out  1  sticky, set on any fail, cleared only by reset

Behaviour:
- Reset (async assert, sync-release use of clk):
  - s=0, r=0, done=0, fail=0, level=0, fault=0.
  - State IDLE, so cmd_ready=1.
  - Synchroniser flops cleared to 0.
  - Assertion mid-command drops s/r to 0 immediately, without a clock edge.
- q_fb and qb_fb each pass through a 2-flop synchroniser; only the synchronised values are used.
- FSM states: IDLE, GUARD, PULSE, SETTLE, CHECK.
  - IDLE: cmd_ready=1, s=r=0. On handshake, capture cmd_set into dir and go to GUARD.
  - GUARD: s=r=0 for GAP_W cycles, then PULSE.
  - PULSE: s=dir, r=~dir for PULSE_W cycles, then SETTLE.
  - SETTLE: s=r=0 for SETTLE_W cycles, then CHECK.
  - CHECK (1 cycle): done=1.
    - fail=1 unless sync_q==dir and sync_qb==~dir; q_fb==qb_fb always fails.
    - On pass, level<=dir; on fail, level is unchanged and fault<=1.
    - Next state IDLE.
- cmd_ready=1 only in IDLE. cmd_valid and cmd_set are ignored in all other states; no queuing.
- Latency, counting cycles after the accept edge:
  - GUARD occupies cycles 1..GAP_W.
  - Pulse occupies the next PULSE_W cycles.
  - done falls in cycle GAP_W+PULSE_W+SETTLE_W+1. With defaults, done is in cycle 6.
  - cmd_ready returns 1 the cycle after done.
  - Back-to-back accept is possible on the first IDLE cycle.
- Invariants:
  - s&r never 1.
  - Between any two pulses there are at least SETTLE_W+GAP_W cycles with s=r=0.
  - done and fail are 0 outside CHECK.
- A redundant command (dir==level) runs the full sequence; no skipping.
- A PULSE_W, GAP_W or SETTLE_W value of 0 is illegal. The block behaves as if the value were 1.

Test Plan:
- Reset: rst_n=0 with random inputs -> s=0, r=0, cmd_ready=1, done=0, fail=0, level=0, fault=0. Release with cmd_valid=0 -> outputs unchanged.
- Set command against a NOR-latch behavioural model, cmd_set=1 accepted at edge E0 -> s=0 in cycle 1; s=1 in cycles 2-3; r=0 throughout; done=1 and fail=0 in cycle 6; level=1; cmd_ready=1 in cycle 7.
- Back-to-back: cmd_valid held high with cmd_set=0 through the previous command -> accepted on the first IDLE cycle, r high for exactly 2 cycles, s never high, done/fail=0 six cycles later, level=0.
- Stuck feedback: model forces q_fb=0, qb_fb=1 on a set command -> done with fail=1, fault=1, level stays 0. A subsequent good reset command gives fail=0 while fault stays 1.
- Async reset during PULSE (s=1): rst_n low between edges -> s=0 immediately, fault cleared. After release, cmd_ready=1 and a new command completes normally.
- Parameters PULSE_W=4, GAP_W=3, SETTLE_W=3 with a 200-command random stream -> done exactly 11 cycles after each accept, pulses exactly 4 cycles, s&r never 1, level tracks the model q.
